// File: rtl/cordic_polar_to_rect_12_pkg.sv
// Shared constants, state encoding and output rounding for the 12-bit polar-to-rectangular CORDIC.
// Angles use 1024 units per 45 degrees.
package cordic_polar_to_rect_12_pkg;

    localparam int ITER   = 11;
    localparam int KINV   = 622;
    localparam int FRAC   = 4;
    localparam int ANG_45 = 1024;
    localparam int ANG_90 = 2048;
    localparam int XY_W   = 16;
    localparam int Z_W    = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_DONE
    } state_t;

    // Round half-up on the guard bits, then saturate to the unsigned 10-bit pixel range.
    function automatic logic [9:0] round_clamp(input logic signed [XY_W-1:0] v);
        logic signed [XY_W:0] sum;
        logic signed [XY_W:0] shifted;
        sum     = $signed({v[XY_W-1], v}) + (XY_W+1)'(1 << (FRAC-1));
        shifted = sum >>> FRAC;
        if (shifted < 0)
            return 10'd0;
        else if (shifted > (XY_W+1)'(1023))
            return 10'd1023;
        else
            return 10'(shifted);
    endfunction

endpackage

// File: rtl/cordic_microrot_12.sv
// One combinational CORDIC micro-rotation in rotation mode; direction follows the sign of z.
module cordic_microrot_12
    import cordic_polar_to_rect_12_pkg::*;
(
    input  logic signed [XY_W-1:0] x,
    input  logic signed [XY_W-1:0] y,
    input  logic signed [Z_W-1:0]  z,
    input  logic        [11:0]     thetai,
    input  logic        [3:0]      shift,
    output logic signed [XY_W-1:0] x_next,
    output logic signed [XY_W-1:0] y_next,
    output logic signed [Z_W-1:0]  z_next
);

    logic signed [XY_W-1:0] x_sh;
    logic signed [XY_W-1:0] y_sh;
    logic signed [Z_W-1:0]  step;

    assign x_sh = x >>> shift;
    assign y_sh = y >>> shift;
    assign step = $signed({2'b00, thetai});

    always_comb begin
        if (z >= 0) begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - step;
        end else begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + step;
        end
    end

endmodule

// File: rtl/cordic_polar_to_rect_12.sv
// Iterative rotation-mode CORDIC: (R, Theta) -> saturated (X, Y), one micro-rotation per cycle.
// The arctangent table lives outside; Count3 addresses it and Thetai returns combinationally.
module cordic_polar_to_rect_12
    import cordic_polar_to_rect_12_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [9:0]  R,
    input  logic [11:0] Theta,
    input  logic [11:0] Thetai,
    output logic [3:0]  Count3,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    output logic        Busy,
    output logic        Done
);

    state_t                 state;
    logic signed [XY_W-1:0] x, y;
    logic signed [Z_W-1:0]  z;
    logic signed [XY_W-1:0] x_next, y_next;
    logic signed [Z_W-1:0]  z_next;
    logic        [19:0]     prod;
    logic signed [XY_W-1:0] x_load;
    logic        [11:0]     theta_clamped;

    // Pre-scale by 1/K so the rotated vector comes out at the true radius.
    assign prod          = 20'(R) * 20'(KINV);
    assign x_load        = XY_W'(prod >> (10 - FRAC));
    assign theta_clamped = (Theta > 12'(ANG_90)) ? 12'(ANG_90) : Theta;

    cordic_microrot_12 u_microrot (
        .x      (x),
        .y      (y),
        .z      (z),
        .thetai (Thetai),
        .shift  (Count3),
        .x_next (x_next),
        .y_next (y_next),
        .z_next (z_next)
    );

    // NOTE: every register, datapath included, resets asynchronously and is written with <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            Count3 <= 4'd0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            X      <= 10'd0;
            Y      <= 10'd0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        x      <= x_load;
                        y      <= '0;
                        z      <= $signed({2'b00, theta_clamped});
                        Count3 <= 4'd0;
                        Busy   <= 1'b1;
                        state  <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    x <= x_next;
                    y <= y_next;
                    z <= z_next;
                    if (Count3 == 4'(ITER - 1)) begin
                        Count3 <= 4'd0;
                        state  <= ST_DONE;
                    end else begin
                        Count3 <= Count3 + 4'd1;
                    end
                end
                ST_DONE: begin
                    X      <= round_clamp(x);
                    Y      <= round_clamp(y);
                    Done   <= 1'b1;
                    Busy   <= 1'b0;
                    Count3 <= 4'd0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
